// File: rtl/pacman_gfx_pkg.sv
// Shared graphics definitions for the pacman display path: screen geometry,
// coordinate widths and the background-capture state encoding.
package pacman_gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        RESTORE,
        FINISH
    } sprite_bg_state_t;

endpackage

// File: rtl/sprite_buf.sv
// Sprite background buffer: DEPTH x CW simple dual-port RAM with one write
// port and two independent registered read ports (old data on collision).
module sprite_buf #(
    parameter int DEPTH = 25,
    parameter int CW    = 3,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic [AW-1:0] rd_a_addr,
    output logic [CW-1:0] rd_a_data,
    input  logic [AW-1:0] rd_b_addr,
    output logic [CW-1:0] rd_b_data
);

    logic [CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        rd_a_data <= mem[rd_a_addr];
        rd_b_data <= mem[rd_b_addr];
    end

endmodule

// File: rtl/sprite_bg_capture.sv
// Captures the W x H framebuffer rectangle under a sprite into a local buffer.
// Define SPRITE_BG_RESTORE_EN to add the replay path to the VGA write port.
module sprite_bg_capture
    import pacman_gfx_pkg::*;
#(
    parameter int W  = 5,
    parameter int H  = 5,
    parameter int CW = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [X_W-1:0]           org_x,
    input  logic [Y_W-1:0]           org_y,
    output logic [X_W-1:0]           fb_rd_x,
    output logic [Y_W-1:0]           fb_rd_y,
    input  logic [CW-1:0]            fb_rd_data,
`ifdef SPRITE_BG_RESTORE_EN
    input  logic                     restore,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [CW-1:0]            colour,
    output logic                     plot,
`endif
    input  logic [$clog2(W*H)-1:0]   buf_rd_addr,
    output logic [CW-1:0]            buf_rd_data,
    output logic                     busy,
    output logic                     done
);

    localparam int N   = W * H;
    localparam int KW  = $clog2(N);
    localparam int CXW = (W > 1) ? $clog2(W) : 1;
    localparam int CYW = (H > 1) ? $clog2(H) : 1;

    sprite_bg_state_t state, state_nxt;

    logic [X_W-1:0] org_x_q;
    logic [Y_W-1:0] org_y_q;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [KW-1:0]  k;
    logic           last;
    logic           step;
    logic           accept;
    logic           wr_vld_p1;
    logic [KW-1:0]  wr_idx_p1;
    logic [KW-1:0]  rst_rd_addr;
    logic [CW-1:0]  rst_rd_data;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;

    assign k     = KW'(cy) * KW'(W) + KW'(cx);
    assign last  = (k == KW'(N - 1));
    assign pix_x = org_x_q + X_W'(cx);
    assign pix_y = org_y_q + Y_W'(cy);

    assign fb_rd_x = pix_x;
    assign fb_rd_y = pix_y;
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    // FINISH behaves like IDLE for new requests so operations can run back to back.
    assign accept  = ((state == IDLE) || (state == FINISH)) && (state_nxt != IDLE);

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        case (state)
            IDLE, FINISH: begin
                state_nxt = IDLE;
                if (start) state_nxt = CAPTURE;
`ifdef SPRITE_BG_RESTORE_EN
                else if (restore) state_nxt = RESTORE;
`endif
            end
            CAPTURE: begin
                step = 1'b1;
                if (last) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = FINISH;
`ifdef SPRITE_BG_RESTORE_EN
            RESTORE: begin
                step = 1'b1;
                if (last) state_nxt = FINISH;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            org_x_q   <= '0;
            org_y_q   <= '0;
            wr_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_vld_p1 <= (state == CAPTURE);
            if (accept) begin
                cx <= '0;
                cy <= '0;
                if (start) begin
                    org_x_q <= org_x;
                    org_y_q <= org_y;
                end
            end else if (step) begin
                if (last) begin
                    cx <= '0;
                    cy <= '0;
                end else if (cx == CXW'(W - 1)) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
        end
    end

    // p1: framebuffer data returns one cycle after its address; index follows it
    always_ff @(posedge clk) begin
        wr_idx_p1 <= k;
    end

`ifdef SPRITE_BG_RESTORE_EN
    // Read one pixel ahead so the registered colour lines up with pix_x/pix_y.
    assign rst_rd_addr = (state == RESTORE && !last) ? k + 1'b1 : '0;
    assign plot        = (state == RESTORE);
    assign vga_x       = plot ? pix_x : '0;
    assign vga_y       = plot ? pix_y : '0;
    assign colour      = plot ? rst_rd_data : '0;
`else
    logic [CW-1:0] unused_rst_rd_data;
    assign rst_rd_addr        = '0;
    assign unused_rst_rd_data = rst_rd_data;
`endif

    sprite_buf #(
        .DEPTH (N),
        .CW    (CW),
        .AW    (KW)
    ) u_buf (
        .clk       (clk),
        .wr_en     (wr_vld_p1),
        .wr_addr   (wr_idx_p1),
        .wr_data   (fb_rd_data),
        .rd_a_addr (rst_rd_addr),
        .rd_a_data (rst_rd_data),
        .rd_b_addr (buf_rd_addr),
        .rd_b_data (buf_rd_data)
    );

endmodule

// File: tb/tb_sprite_bg_capture.sv
// Bench for sprite_bg_capture against a framebuffer array and a rectangle model;
// restore scenarios are included when SPRITE_BG_RESTORE_EN is defined.
module tb_sprite_bg_capture;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CW = 3;
    localparam int N  = W * H;
    localparam int KW = $clog2(N);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    org_x = '0;
    logic [6:0]    org_y = '0;
    logic [7:0]    fb_rd_x;
    logic [6:0]    fb_rd_y;
    logic [CW-1:0] fb_rd_data = '0;
    logic [KW-1:0] buf_rd_addr = '0;
    logic [CW-1:0] buf_rd_data;
    logic          busy;
    logic          done;
`ifdef SPRITE_BG_RESTORE_EN
    logic          restore = 1'b0;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CW-1:0] colour;
    logic          plot;
`endif

    int checks = 0;
    int errors = 0;
    int last_ox = 0;
    int last_oy = 0;

    logic [CW-1:0] fb_mem [256][128];
    logic [CW-1:0] mbuf [N];

    sprite_bg_capture #(.W(W), .H(H), .CW(CW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .org_x       (org_x),
        .org_y       (org_y),
        .fb_rd_x     (fb_rd_x),
        .fb_rd_y     (fb_rd_y),
        .fb_rd_data  (fb_rd_data),
`ifdef SPRITE_BG_RESTORE_EN
        .restore     (restore),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .colour      (colour),
        .plot        (plot),
`endif
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Framebuffer read port: one cycle of latency
    always @(posedge clk) fb_rd_data <= fb_mem[fb_rd_x][fb_rd_y];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_fb(input bit sum_mode);
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                fb_mem[x][y] = sum_mode ? CW'((x + y) % 8) : CW'($urandom);
    endtask

    task automatic run_capture(input int ox, input int oy, input int poke, input bit with_restore);
        int kk;
        @(negedge clk);
        start = 1'b1;
        org_x = 8'(ox);
        org_y = 7'(oy);
`ifdef SPRITE_BG_RESTORE_EN
        restore = with_restore;
`else
        if (with_restore) org_x = 8'(ox);
`endif
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            if (c == 1 || c == poke + 1) begin
                start = 1'b0;
`ifdef SPRITE_BG_RESTORE_EN
                restore = 1'b0;
`endif
            end
            if (c == poke) begin
                start = 1'b1;
                org_x = 8'($urandom);
                org_y = 7'($urandom);
            end
            check("cap_busy", 32'(busy), 32'd1);
            check("cap_done", 32'(done), 32'(c == N + 2));
            if (c <= N) begin
                kk = c - 1;
                check("cap_x", 32'(fb_rd_x), 32'((ox + kk % W) % 256));
                check("cap_y", 32'(fb_rd_y), 32'((oy + kk / W) % 128));
            end
        end
        @(negedge clk);
        check("cap_end_busy", 32'(busy), 32'd0);
        check("cap_end_done", 32'(done), 32'd0);
        for (int j = 0; j < N; j++)
            mbuf[j] = fb_mem[(ox + j % W) % 256][(oy + j / W) % 128];
        last_ox = ox;
        last_oy = oy;
    endtask

    task automatic verify_buf();
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            buf_rd_addr = KW'(j);
            @(negedge clk);
            check("buf_rd", 32'(buf_rd_data), 32'(mbuf[j]));
        end
    endtask

`ifdef SPRITE_BG_RESTORE_EN
    task automatic run_restore();
        int kk;
        @(negedge clk);
        restore = 1'b1;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            if (c == 1) restore = 1'b0;
            check("rst_busy", 32'(busy), 32'd1);
            check("rst_done", 32'(done), 32'(c == N + 1));
            check("rst_plot", 32'(plot), 32'(c <= N));
            if (c <= N) begin
                kk = c - 1;
                check("rst_x", 32'(vga_x), 32'((last_ox + kk % W) % 256));
                check("rst_y", 32'(vga_y), 32'((last_oy + kk / W) % 128));
                check("rst_colour", 32'(colour), 32'(mbuf[kk]));
            end
        end
        @(negedge clk);
        check("rst_end_busy", 32'(busy), 32'd0);
        check("rst_end_plot", 32'(plot), 32'd0);
    endtask
`endif

    task automatic reset_mid_capture();
        @(negedge clk);
        start = 1'b1;
        org_x = 8'($urandom);
        org_y = 7'($urandom);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check("mid_done", 32'(done), 32'd0);
            if (c == 10) resetn = 1'b0;
        end
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_x", 32'(fb_rd_x), 32'd0);
        check("rstmid_y", 32'(fb_rd_y), 32'd0);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        fill_fb(1'b1);
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_x", 32'(fb_rd_x), 32'd0);
        check("reset_y", 32'(fb_rd_y), 32'd0);
`ifdef SPRITE_BG_RESTORE_EN
        check("reset_plot", 32'(plot), 32'd0);
        check("reset_vga_x", 32'(vga_x), 32'd0);
`endif
        resetn = 1'b1;

        run_capture(10, 20, 0, 1'b0);
        verify_buf();
`ifdef SPRITE_BG_RESTORE_EN
        run_restore();
`endif

        fill_fb(1'b0);
        run_capture(158, 118, 0, 1'b0);
        verify_buf();
`ifdef SPRITE_BG_RESTORE_EN
        run_restore();
`endif

        run_capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 5, 1'b0);
        verify_buf();

        run_capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 0, 1'b1);
        verify_buf();

        reset_mid_capture();
        run_capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 0, 1'b0);
        verify_buf();
`ifdef SPRITE_BG_RESTORE_EN
        run_restore();
`endif

        for (int r = 0; r < 3; r++) begin
            fill_fb(1'b0);
            run_capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                        int'($urandom_range(0, N)), 1'b0);
            verify_buf();
`ifdef SPRITE_BG_RESTORE_EN
            run_restore();
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
